// File: rtl/ips_filter_pkg.sv
// ips_filter_pkg: shared drive constants for IPS sensor conditioning
package ips_filter_pkg;
  localparam int ACLK_HZ = 50_000_000;
  localparam int SYNC_STAGES_DEF = 2;
  // 20 us of stable input before a sensor level is accepted
  localparam int DEBOUNCE_CYCLES_DEF = ACLK_HZ / 50_000;
  // 1 ms with no sensor on the line before it is declared lost
  localparam int LOST_CYCLES_DEF = ACLK_HZ / 1_000;
  localparam int SENS_L = 2;
  localparam int SENS_C = 1;
  localparam int SENS_R = 0;
  typedef logic [2:0] sens_t;
endpackage

// File: rtl/ips_debounce.sv
// ips_debounce: single-channel synchroniser plus stable-count debouncer
module ips_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic out,
  output logic flip
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  assign flip = (s != out) && (cnt == LAST);
  // shift raw input through the synchroniser chain
  always_ff @(posedge clk) begin
    if (!rstn) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], raw};
  end
  // count consecutive disagreeing cycles; any agreement restarts qualification
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (s == out) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      out <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ips_filter.sv
// ips_filter: debounced L/C/R sensor levels with change pulse and line-lost flag
module ips_filter
  import ips_filter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LOST_CYCLES = LOST_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic IPS_L,
  input  logic IPS_C,
  input  logic IPS_R,
  output logic L,
  output logic C,
  output logic R,
  output logic Change,
  output logic Lost
);
  localparam int LW = $clog2(LOST_CYCLES + 1);
  localparam logic [LW-1:0] LMAX = LW'(LOST_CYCLES);
  sens_t raw, lvl, flip;
  logic [LW-1:0] lcnt;
  assign raw[SENS_L] = IPS_L;
  assign raw[SENS_C] = IPS_C;
  assign raw[SENS_R] = IPS_R;
  for (genvar g = 0; g < 3; g++) begin : g_ch
    ips_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk(CLK),
      .rstn(RSTn),
      .raw(raw[g]),
      .out(lvl[g]),
      .flip(flip[g])
    );
  end
  assign L = lvl[SENS_L];
  assign C = lvl[SENS_C];
  assign R = lvl[SENS_R];
  // pulse on any flip; time how long every sensor has been off the line, saturating
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      lcnt <= '0;
      Change <= 1'b0;
      Lost <= 1'b0;
    end else begin
      Change <= |flip;
      if (|lvl) begin
        lcnt <= '0;
        Lost <= 1'b0;
      end else if (lcnt < LMAX) begin
        lcnt <= lcnt + 1'b1;
        Lost <= (lcnt + 1'b1 == LMAX);
      end
    end
  end
endmodule

// File: tb/tb_ips_filter.sv
// tb_ips_filter: randomized and directed stimulus against a sample-history reference model
module tb_ips_filter;
  localparam int SYNC = 2;
  localparam int DEB = 4;
  localparam int LOST = 8;
  localparam int HD = SYNC + DEB;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic IPS_L = 1'b0, IPS_C = 1'b0, IPS_R = 1'b0;
  logic L, C, R, Change, Lost;
  int total = 0;
  int bad = 0;
  bit [2:0] hist [HD];
  bit [2:0] mo = '0;
  bit mchg = 1'b0;
  bit mlost = 1'b0;
  int zc = 0;
  int run [3];
  bit [2:0] cur = '0;

  ips_filter #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LOST_CYCLES(LOST)) dut (
    .CLK(CLK), .RSTn(RSTn), .IPS_L(IPS_L), .IPS_C(IPS_C), .IPS_R(IPS_R),
    .L(L), .C(C), .R(R), .Change(Change), .Lost(Lost)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", tag, $time, obs, exp);
    end
  endtask

  // Model: a level flips once the last DEB synchronised samples (raw delayed by SYNC)
  // all disagree with it; Lost once outputs have been all-zero for LOST edges.
  task automatic tick(input bit [2:0] raw, input bit rn);
    bit [2:0] prev;
    bit [2:0] flip;
    {IPS_L, IPS_C, IPS_R} = raw;
    RSTn = rn;
    @(posedge CLK);
    if (!rn) begin
      foreach (hist[j]) hist[j] = '0;
      mo = '0;
      mchg = 1'b0;
      mlost = 1'b0;
      zc = 0;
    end else begin
      prev = mo;
      for (int j = HD - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = raw;
      flip = '1;
      for (int c = 0; c < 3; c++)
        for (int j = SYNC; j < HD; j++)
          if (hist[j][c] == mo[c]) flip[c] = 1'b0;
      zc = (prev == 0) ? zc + 1 : 0;
      mlost = zc >= LOST;
      mo ^= flip;
      mchg = |flip;
    end
    #1;
    chk("L", L, mo[2]);
    chk("C", C, mo[1]);
    chk("R", R, mo[0]);
    chk("Change", Change, mchg);
    chk("Lost", Lost, mlost);
  endtask

  task automatic hold(input bit [2:0] raw, input int n);
    for (int i = 0; i < n; i++) tick(raw, 1'b1);
  endtask

  initial begin
    foreach (hist[j]) hist[j] = '0;
    for (int i = 0; i < 3; i++) tick(3'b000, 1'b0);
    hold(3'b000, 7);
    chk("lost_before_8", Lost, 1'b0);
    hold(3'b000, 1);
    chk("lost_at_8", Lost, 1'b1);
    hold(3'b010, 5);
    chk("c_not_at_5", C, 1'b0);
    hold(3'b010, 1);
    chk("c_at_6", C, 1'b1);
    chk("chg_at_6", Change, 1'b1);
    hold(3'b010, 1);
    chk("chg_gone_7", Change, 1'b0);
    chk("lost_clear_7", Lost, 1'b0);
    hold(3'b000, 12);
    hold(3'b100, 3);
    hold(3'b000, 10);
    hold(3'b100, 4);
    hold(3'b000, 12);
    hold(3'b101, 10);
    hold(3'b000, 12);
    tick(3'b001, 1'b0);
    hold(3'b001, 4);
    tick(3'b001, 1'b0);
    hold(3'b001, 5);
    chk("r_not_at_5", R, 1'b0);
    hold(3'b001, 1);
    chk("r_at_6", R, 1'b1);
    hold(3'b000, 100);
    chk("lost_saturated", Lost, 1'b1);
    hold(3'b010, 6);
    chk("c_up_lost_held", Lost, 1'b1);
    hold(3'b010, 1);
    chk("lost_drop", Lost, 1'b0);
    foreach (run[c]) run[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (run[c] == 0) begin
          cur[c] = $urandom_range(0, 2) == 0;
          run[c] = $urandom_range(1, 8);
        end
        run[c]--;
      end
      if ((n % 300) > 270) tick(3'b000, 1'b1);
      else tick(cur, $urandom_range(0, 149) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
